// File: rtl/fir_tap_sequencer.sv
// Sequencer for the 64-tap FIR datapath. It accepts a sample, strobes the delay
// pipeline, sweeps the tap index for the MAC and hands the result downstream.
module fir_tap_sequencer #(
    parameter int NUM_TAPS    = 64,
    parameter int COUNT_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_sample_valid,
    output logic                   o_sample_ready,
    output logic                   phase_63,
    output logic [COUNT_WIDTH-1:0] current_count,
    output logic                   acc_clear,
    output logic                   acc_enable,
    output logic                   o_result_valid,
    input  logic                   i_result_ready,
    output logic                   o_busy
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [COUNT_WIDTH-1:0] LAST_TAP = COUNT_WIDTH'(NUM_TAPS - 1);

    state_t                 r_state;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   r_sample_ready;
    logic                   r_phase;
    logic                   r_clear;
    logic                   r_enable;
    logic                   r_result_valid;
    logic                   r_busy;

    // Outputs are registered alongside the state they belong to, so each
    // branch loads the output values of the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_count        <= '0;
            r_sample_ready <= 1'b0;
            r_phase        <= 1'b0;
            r_clear        <= 1'b0;
            r_enable       <= 1'b0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_sample_ready <= 1'b0;
            r_phase        <= 1'b0;
            r_clear        <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_sample_valid) begin
                        r_state        <= LOAD;
                        r_sample_ready <= 1'b1;
                        r_phase        <= 1'b1;
                        r_busy         <= 1'b1;
                    end
                end
                LOAD: begin
                    r_state  <= RUN;
                    r_count  <= '0;
                    r_enable <= 1'b1;
                    r_clear  <= 1'b1;
                end
                RUN: begin
                    if (r_count == LAST_TAP) begin
                        r_state        <= DONE;
                        r_count        <= '0;
                        r_enable       <= 1'b0;
                        r_result_valid <= 1'b1;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                DONE: begin
                    if (i_result_ready) begin
                        r_result_valid <= 1'b0;
                        // Back-to-back: a waiting sample is taken straight from DONE.
                        if (i_sample_valid) begin
                            r_state        <= LOAD;
                            r_sample_ready <= 1'b1;
                            r_phase        <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state        <= IDLE;
                    r_count        <= '0;
                    r_enable       <= 1'b0;
                    r_result_valid <= 1'b0;
                    r_busy         <= 1'b0;
                end
            endcase
        end
    end

    assign o_sample_ready = r_sample_ready;
    assign phase_63       = r_phase;
    assign current_count  = r_count;
    assign acc_clear      = r_clear;
    assign acc_enable     = r_enable;
    assign o_result_valid = r_result_valid;
    assign o_busy         = r_busy;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: a timeline model of each accepted sample predicts
// every output each cycle, and directed scenarios pin the model with literal cycles.
module tb_fir_tap_sequencer;
    localparam int NT = 64;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_sample_valid = 1'b0;
    logic          o_sample_ready;
    logic          phase_63;
    logic [CW-1:0] current_count;
    logic          acc_clear;
    logic          acc_enable;
    logic          o_result_valid;
    logic          i_result_ready = 1'b0;
    logic          o_busy;

    fir_tap_sequencer #(.NUM_TAPS(NT), .COUNT_WIDTH(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_sample_valid (i_sample_valid),
        .o_sample_ready (o_sample_ready),
        .phase_63       (phase_63),
        .current_count  (current_count),
        .acc_clear      (acc_clear),
        .acc_enable     (acc_enable),
        .o_result_valid (o_result_valid),
        .i_result_ready (i_result_ready),
        .o_busy         (o_busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;
    logic [CW+5:0] e_vec;

    int q_phase[$];
    int q_clear[$];
    int q_rv[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model: each accepted sample occupies a timeline starting at its LOAD cycle:
    // offset 0 = accept, 1..NT = tap sweep, NT+1.. = result waiting for ready.
    initial begin : model
        bit active;
        int load_cyc;
        int prev_off;
        int off;
        active   = 1'b0;
        load_cyc = -1000;
        e_vec    = '0;
        forever begin
            @(posedge clk);
            prev_off = cyc - load_cyc;
            cyc++;
            if (rst) begin
                active = 1'b0;
            end else if (!active) begin
                if (i_sample_valid) begin
                    active   = 1'b1;
                    load_cyc = cyc;
                end
            end else if (prev_off >= NT + 1 && i_result_ready) begin
                if (i_sample_valid) load_cyc = cyc;
                else active = 1'b0;
            end
            e_vec = '0;
            if (active) begin
                off = cyc - load_cyc;
                if (off == 0)
                    e_vec = {1'b1, 1'b1, CW'(0), 1'b0, 1'b0, 1'b0, 1'b1};
                else if (off <= NT)
                    e_vec = {1'b0, 1'b0, CW'(off - 1), (off == 1), 1'b1, 1'b0, 1'b1};
                else
                    e_vec = {1'b0, 1'b0, CW'(0), 1'b0, 1'b0, 1'b1, 1'b1};
            end
            chk_en = 1'b1;
        end
    end

    // Compare and event log, sampled mid-cycle.
    initial begin : compare
        logic [CW+5:0] a_vec;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                a_vec = {o_sample_ready, phase_63, current_count, acc_clear,
                         acc_enable, o_result_valid, o_busy};
                checks++;
                if (a_vec !== e_vec) begin
                    failures++;
                    $display("FAIL outputs cycle %0d: got %h expected %h", cyc, a_vec, e_vec);
                end
                if (o_sample_ready) chk("proto_valid_in_load", int'(i_sample_valid), 1);
                if (phase_63)       q_phase.push_back(cyc);
                if (acc_clear)      q_clear.push_back(cyc);
                if (o_result_valid) q_rv.push_back(cyc);
            end
        end
    end

    task automatic clr_logs();
        q_phase.delete();
        q_clear.delete();
        q_rv.delete();
    endtask

    initial begin : stim
        int t0;
        // Reset then idle
        tick(2);
        rst = 1'b0;
        tick(10);
        @(negedge clk);
        chk("idle_busy", int'(o_busy), 0);
        chk("idle_count", int'(current_count), 0);
        chk("idle_no_phase", q_phase.size(), 0);

        // Single sample
        tick(1);
        clr_logs();
        i_result_ready = 1'b1;
        t0 = cyc;
        i_sample_valid = 1'b1;
        tick(2);
        i_sample_valid = 1'b0;
        tick(72);
        chk("single_phase_n", q_phase.size(), 1);
        if (q_phase.size() == 1) chk("single_phase_cyc", q_phase[0] - t0, 1);
        chk("single_clear_n", q_clear.size(), 1);
        if (q_clear.size() == 1) chk("single_clear_cyc", q_clear[0] - t0, 2);
        chk("single_rv_n", q_rv.size(), 1);
        if (q_rv.size() == 1) chk("single_rv_cyc", q_rv[0] - t0, 66);

        // Result back-pressure: 20 extra cycles in DONE
        clr_logs();
        i_result_ready = 1'b0;
        t0 = cyc;
        i_sample_valid = 1'b1;
        tick(2);
        i_sample_valid = 1'b0;
        tick(64);
        @(negedge clk);
        chk("bp_done_count", int'(current_count), 0);
        chk("bp_done_enable", int'(acc_enable), 0);
        tick(20);
        i_result_ready = 1'b1;
        tick(3);
        chk("bp_rv_n", q_rv.size(), 21);
        if (q_rv.size() > 0) chk("bp_rv_first", q_rv[0] - t0, 66);
        @(negedge clk);
        chk("bp_idle_busy", int'(o_busy), 0);

        // Back-to-back: three samples with valid held
        tick(1);
        clr_logs();
        t0 = cyc;
        i_sample_valid = 1'b1;
        tick(134);
        i_sample_valid = 1'b0;
        tick(70);
        chk("b2b_phase_n", q_phase.size(), 3);
        chk("b2b_clear_n", q_clear.size(), 3);
        if (q_phase.size() == 3) begin
            chk("b2b_phase0", q_phase[0] - t0, 1);
            chk("b2b_gap1", q_phase[1] - q_phase[0], 66);
            chk("b2b_gap2", q_phase[2] - q_phase[1], 66);
        end

        // Reset mid-run at current_count = 30
        clr_logs();
        t0 = cyc;
        i_sample_valid = 1'b1;
        tick(2);
        i_sample_valid = 1'b0;
        tick(30);
        @(negedge clk);
        chk("mid_count30", int'(current_count), 30);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", int'(o_busy), 0);
        chk("mid_rst_count", int'(current_count), 0);
        chk("mid_rst_enable", int'(acc_enable), 0);
        tick(70);
        chk("mid_no_rv", q_rv.size(), 0);
        clr_logs();
        i_sample_valid = 1'b1;
        tick(2);
        i_sample_valid = 1'b0;
        tick(70);
        chk("post_rst_phase_n", q_phase.size(), 1);
        chk("post_rst_rv_n", q_rv.size(), 1);

        // Blocked input: second sample waits through RUN and a stalled DONE
        clr_logs();
        i_result_ready = 1'b0;
        t0 = cyc;
        i_sample_valid = 1'b1;
        tick(2);
        i_sample_valid = 1'b0;
        tick(10);
        i_sample_valid = 1'b1;
        tick(59);
        i_result_ready = 1'b1;
        tick(2);
        i_sample_valid = 1'b0;
        tick(70);
        chk("blk_phase_n", q_phase.size(), 2);
        if (q_phase.size() == 2) begin
            chk("blk_phase0", q_phase[0] - t0, 1);
            chk("blk_phase1", q_phase[1] - t0, 72);
        end
        chk("blk_clear_n", q_clear.size(), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
